cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Common Data Bus (CDB) arbiter for the Tomasulo core.
// - Functional units raise result requests (label + data); one winner per cycle drives the broadcast bus.
// - The broadcast bus is BCEN/BClabel/BCdata, which feeds every ReservationStation and the register status table.
// - Round-robin fairness, so no FU starves; broadcast outputs are registered.
// PARAMETERS
// - N_REQ    4   number of requesting functional units (2..8)
// - DATA_W   32  result data width
// - LABEL_W  5   reservation-station tag width; tag 0 = "no tag / value ready"
// PORTS
// - clk       in   1              system clock, rising edge
// - rst       in   1              asynchronous, active-high reset
// - req       in   N_REQ          per-FU result valid; held until granted
// - reqLabel  in   N_REQ*LABEL_W  per-FU producing tag, FU i at [i*LABEL_W +: LABEL_W]
// - reqData   in   N_REQ*DATA_W   per-FU result, FU i at [i*DATA_W +: DATA_W]
// - grant     out  N_REQ          one-hot, combinational; transfer happens at the edge where req[i]&grant[i]
// - BCEN      out  1              broadcast valid (registered)
// - BClabel   out  LABEL_W        broadcast tag (registered)
// - BCdata    out  DATA_W         broadcast value (registered)
// - bcStall   in   1              downstream stall (only with CDB_HOLD_EN)
// BEHAVIOUR
// - Reset values (async, immediate): BCEN=0, BClabel=0, BCdata=0, ptr=0; grant=0 while rst is high.
// - Pick rule: the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... with wrap modulo N_REQ.
// - grant is one-hot of the winner, or all zero if req==0.
// - Transfer at posedge when |grant:
//   - BCEN<=1, BClabel<=reqLabel[w], BCdata<=reqData[w];
//   - ptr<=(w+1)%N_REQ.
// - At posedge with no grant: BCEN<=0; BClabel/BCdata hold their last value; ptr holds.
// - Latency: request accepted in cycle t -> broadcast visible for exactly one cycle, t+1.
// - Throughput: one broadcast per cycle, back-to-back allowed.
// - Handshake: an FU keeps req, reqLabel and reqData stable until it sees grant at an edge.
//   - After that edge it drops req or presents its next result.
//   - A req not granted is never lost.
// - Tag 0: a req with reqLabel==0 is a protocol error.
//   - It is still arbitrated and broadcast, but it wakes nothing.
//   - The bench flags it with an assertion.
// - Simultaneous: all N_REQ requesting -> grants rotate 0,1,2,3,0,... each FU served within N_REQ cycles.
// - Wrap-around: ptr = N_REQ-1 with only req[0] set -> FU 0 is granted and ptr becomes 1.
// - Reset mid-operation: an in-flight broadcast is dropped (BCEN falls asynchronously).
//   - Pending FUs keep req high and are re-arbitrated from ptr=0 after rst is released.
// CONFIGURATION
// - Macro CDB_HOLD_EN:
//   - Defined: port bcStall exists. While bcStall=1, grant=0, BCEN/BClabel/BCdata hold their current values unchanged, and ptr holds.
//   - Not defined: no bcStall port; the arbiter grants every cycle that has a request.
// STRUCTURE
// - Package tomasulo_pkg: LABEL_W, DATA_W, NO_LABEL='0, and cdb_bus_t struct {en, label, data}. The struct is shared with ReservationStation.
// - Sub-module rr_pick: purely combinational rotating-priority encoder.
//   - Inputs: req, ptr. Outputs: grant one-hot, winner index, any.
//   - It is reused by the issue-port arbiter.
// - Top level: ptr register, output register, label/data mux selected by the winner index.
// TESTING
// - Reset: rst=1 with req=4'b1111 -> grant=0, BCEN=0; release rst -> grant=4'b0001, next cycle BCEN=1 with FU0's label.
// - Single: req=4'b0100, reqLabel[2]=5'd2, reqData[2]=32 -> grant=4'b0100 same cycle; next cycle BCEN=1, BClabel=2, BCdata=32; following cycle BCEN=0.
// - Fairness: req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; BCEN high continuously.
// - Wrap: grant FU3 (ptr=0), then req=4'b1001 -> FU0 next, then FU3; ptr sequence 0,1,0.
// - Mid-reset: rst pulsed while BCEN=1, BClabel=7 -> BCEN=0 before the next edge; after release, pending req=4'b0010 is granted first.
// - CDB_HOLD_EN: BCEN=1, BClabel=3, then bcStall=1 for 3 cycles with req=4'b0001 -> grant=0, bus holds label 3; bcStall=0 -> FU0 granted.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: default bus widths, the "no tag" constant and the
// CDB broadcast record consumed by the reservation stations.
package tomasulo_pkg;

  localparam int LABEL_W = 5;
  localparam int DATA_W  = 32;

  localparam logic [LABEL_W-1:0] NO_LABEL = '0;

  typedef struct packed {
    logic               en;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } cdb_bus_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first requester at or after ptr,
// wrapping modulo N. Purely combinational; shared with the issue-port arbiter.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [IW:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k never exceeds 2N-2, so a single conditional subtract wraps it
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!any && req[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        winner             = idx[IW-1:0];
        any                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin choice among FU result requests with a
// registered BCEN/BClabel/BCdata broadcast. Define CDB_HOLD_EN to add bcStall.
module cdb_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = tomasulo_pkg::DATA_W,
  parameter int LABEL_W = tomasulo_pkg::LABEL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LABEL_W-1:0] reqLabel,
  input  logic [N_REQ*DATA_W-1:0]  reqData,
  output logic [N_REQ-1:0]         grant,
  output logic                     BCEN,
  output logic [LABEL_W-1:0]       BClabel,
  output logic [DATA_W-1:0]        BCdata
`ifdef CDB_HOLD_EN
  ,
  input  logic                     bcStall
`endif
);

  import tomasulo_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);

  typedef struct packed {
    logic               en;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } bus_t;

  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   ptr_next;
  bus_t               bus_reg;
  logic               stall;
  logic [N_REQ-1:0]   pick_grant;
  logic [PTR_W-1:0]   pick_winner;
  logic               pick_any;
  logic [LABEL_W-1:0] label_arr [N_REQ];
  logic [DATA_W-1:0]  data_arr  [N_REQ];

`ifdef CDB_HOLD_EN
  assign stall = bcStall;
`else
  assign stall = 1'b0;
`endif

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign label_arr[gi] = reqLabel[gi*LABEL_W +: LABEL_W];
    assign data_arr[gi]  = reqData[gi*DATA_W +: DATA_W];
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .grant  (pick_grant),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // grant is what the FUs see as the handshake, so it must be dead in reset and stall
  assign grant = (rst || stall) ? '0 : pick_grant;

  assign ptr_next = (pick_winner == PTR_W'(N_REQ-1)) ? '0 : pick_winner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= '0;
      bus_reg.en    <= 1'b0;
      bus_reg.label <= LABEL_W'(NO_LABEL);
      bus_reg.data  <= '0;
    end else if (!stall) begin
      if (pick_any) begin
        bus_reg.en    <= 1'b1;
        bus_reg.label <= label_arr[pick_winner];
        bus_reg.data  <= data_arr[pick_winner];
        ptr_reg       <= ptr_next;
      end else begin
        bus_reg.en <= 1'b0;
      end
    end
  end

  assign BCEN    = bus_reg.en;
  assign BClabel = bus_reg.label;
  assign BCdata  = bus_reg.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations, then randomized FU traffic against a behavioural model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int LW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*LW-1:0]   reqLabel = '0;
  logic [N*DW-1:0]   reqData = '0;
  logic [N-1:0]      grant;
  logic              BCEN;
  logic [LW-1:0]     BClabel;
  logic [DW-1:0]     BCdata;
  logic              bcStall = 1'b0;

  int checks = 0;
  int failures = 0;

  cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .LABEL_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .reqLabel (reqLabel),
    .reqData  (reqData),
    .grant    (grant),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata)
`ifdef CDB_HOLD_EN
    ,
    .bcStall  (bcStall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the bus as it should look, and the round-robin start point
  int            m_ptr = 0;
  logic          m_en = 1'b0;
  logic [LW-1:0] m_label = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  exp_grant;
  logic [N-1:0]  xfer_grant = '0;
  int            wait_cnt [N];

  function automatic int model_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial for (int i = 0; i < N; i++) wait_cnt[i] = 0;

  // Compare process: 2 time units after each falling edge inputs are settled
  always @(negedge clk) begin
    int w;
    #2;
    if (rst) begin
      m_ptr = 0; m_en = 1'b0; m_label = '0; m_data = '0;
      exp_grant = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else if (bcStall) begin
      exp_grant = '0;
    end else begin
      w = model_winner(req, m_ptr);
      exp_grant = (w < 0) ? '0 : N'(1) << w;
    end
    check("grant", 64'(grant), 64'(exp_grant));
    check("BCEN", 64'(BCEN), 64'(m_en));
    check("BClabel", 64'(BClabel), 64'(m_label));
    check("BCdata", 64'(BCdata), 64'(m_data));
    xfer_grant = rst ? '0 : grant;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          assert (reqLabel[i*LW +: LW] != '0) else $error("protocol: tag 0 requested by FU %0d", i);
        end
      end
    end
    if (!rst && !bcStall) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !exp_grant[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] >= N) check("starve", 64'(wait_cnt[i]), 64'(N - 1));
        end else begin
          wait_cnt[i] = 0;
        end
      end
      w = model_winner(req, m_ptr);
      if (w >= 0) begin
        m_en    = 1'b1;
        m_label = reqLabel[w*LW +: LW];
        m_data  = reqData[w*DW +: DW];
        m_ptr   = (w + 1) % N;
      end else begin
        m_en = 1'b0;
      end
    end
  end

  task automatic set_fu(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
    reqLabel[i*LW +: LW] = l;
    reqData[i*DW +: DW]  = d;
  endtask

  task automatic cyc(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    #3;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_fu(i, LW'(i + 1), DW'(100 + i));

    // Reset holds off grant even with everyone requesting
    req = 4'b1111;
    @(negedge clk); #3;
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_bcen", 64'(BCEN), 64'h0);
    @(negedge clk); rst = 1'b0; #3;
    check("rel_grant", 64'(grant), 64'b0001);
    cyc(4'b1110);
    check("rel_bcen", 64'(BCEN), 64'h1);
    check("rel_label", 64'(BClabel), 64'd1);
    check("rel_grant2", 64'(grant), 64'b0010);
    cyc(4'b1100); check("rel_grant3", 64'(grant), 64'b0100);
    cyc(4'b1000); check("rel_grant4", 64'(grant), 64'b1000);
    cyc(4'b0000); check("rel_label4", 64'(BClabel), 64'd4);
    cyc(4'b0000); check("idle_bcen", 64'(BCEN), 64'h0);

    // Single requester
    set_fu(2, 5'd2, 32'd32);
    cyc(4'b0100); check("single_grant", 64'(grant), 64'b0100);
    cyc(4'b0000);
    check("single_bcen", 64'(BCEN), 64'h1);
    check("single_label", 64'(BClabel), 64'd2);
    check("single_data", 64'(BCdata), 64'd32);
    cyc(4'b0000);
    check("single_drop", 64'(BCEN), 64'h0);
    check("single_hold", 64'(BClabel), 64'd2);

    // Fairness: ptr is 3 here, so serving FU3 alone brings it back to 0
    set_fu(2, 5'd3, 32'd102);
    cyc(4'b1000); check("pre_fair", 64'(grant), 64'b1000);
    for (int k = 0; k < 8; k++) begin
      cyc(4'b1111);
      check("fair_grant", 64'(grant), 64'(1 << (k % 4)));
      check("fair_bcen", 64'(BCEN), 64'h1);
      if (k > 0) check("fair_label", 64'(BClabel), 64'(((k - 1) % 4) + 1));
    end

    // Wrap-around
    cyc(4'b1000); check("wrap_fu3", 64'(grant), 64'b1000);
    cyc(4'b1001); check("wrap_fu0", 64'(grant), 64'b0001);
    cyc(4'b1000); check("wrap_fu3b", 64'(grant), 64'b1000);
    cyc(4'b0100); check("wrap_fu2", 64'(grant), 64'b0100);
    cyc(4'b0001); check("wrap_ptr3", 64'(grant), 64'b0001);
    cyc(4'b0011); check("wrap_ptr1", 64'(grant), 64'b0010);
    cyc(4'b0001); check("wrap_last", 64'(grant), 64'b0001);
    cyc(4'b0000);

    // Reset in the middle of a broadcast
    set_fu(0, 5'd7, 32'h77);
    cyc(4'b0001); check("mid_grant", 64'(grant), 64'b0001);
    set_fu(1, 5'd9, 32'h99);
    cyc(4'b0010);
    check("mid_bcen", 64'(BCEN), 64'h1);
    check("mid_label", 64'(BClabel), 64'd7);
    #1 rst = 1'b1;
    #1;
    check("mid_async_bcen", 64'(BCEN), 64'h0);
    check("mid_async_label", 64'(BClabel), 64'h0);
    cyc(4'b0010); check("mid_rst_grant", 64'(grant), 64'h0);
    @(negedge clk); rst = 1'b0; #3;
    check("mid_regrant", 64'(grant), 64'b0010);
    cyc(4'b0000);
    check("mid_bc_label", 64'(BClabel), 64'd9);
    check("mid_bc_data", 64'(BCdata), 64'h99);

`ifdef CDB_HOLD_EN
    set_fu(0, 5'd3, 32'h33);
    cyc(4'b0001); check("hold_pre", 64'(grant), 64'b0001);
    set_fu(0, 5'd5, 32'h55);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bcStall = 1'b1; req = 4'b0001; #3;
      check("hold_grant", 64'(grant), 64'h0);
      check("hold_bcen", 64'(BCEN), 64'h1);
      check("hold_label", 64'(BClabel), 64'd3);
    end
    @(negedge clk); bcStall = 1'b0; #3;
    check("hold_release", 64'(grant), 64'b0001);
    cyc(4'b0000); check("hold_after", 64'(BClabel), 64'd5);
`endif

    // Randomized FU traffic obeying the hold-until-granted handshake
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) rst = 1'b1;
      if (c == 1502) rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && xfer_grant[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          if (req[i]) set_fu(i, LW'($urandom_range(1, 31)), $urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_fu(i, LW'($urandom_range(1, 31)), $urandom);
        end
      end
    end
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
